// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and fetches from a variable-latency imem.
// Presents {PC+4, Instruction} to IF/ID, or a zero bubble when nothing is ready.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        if_valid
);

  // DROP: a request is in flight whose data must be thrown away.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] tgt_addr, tgt_addr_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic        buf_valid, buf_valid_n;

  assign imem_req    = (state != FULL);
  assign imem_addr   = req_addr;
  assign if_valid    = buf_valid;
  assign Instruction = buf_valid ? buf_instr : 32'b0;
  assign PC          = buf_valid ? buf_pc + 32'd4 : 32'b0;

  // State and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      req_addr  <= RESET_PC;
      tgt_addr  <= 32'b0;
      buf_instr <= 32'b0;
      buf_pc    <= 32'b0;
      buf_valid <= 1'b0;
    end else begin
      state     <= state_n;
      req_addr  <= req_addr_n;
      tgt_addr  <= tgt_addr_n;
      buf_instr <= buf_instr_n;
      buf_pc    <= buf_pc_n;
      buf_valid <= buf_valid_n;
    end
  end

  // Next state; redirect beats both freeze and an arriving ack.
  always_comb begin
    state_n     = state;
    req_addr_n  = req_addr;
    tgt_addr_n  = tgt_addr;
    buf_instr_n = buf_instr;
    buf_pc_n    = buf_pc;
    buf_valid_n = buf_valid;
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          if (branch_taken) begin
            req_addr_n = branch_addr;
          end else begin
            buf_instr_n = imem_rdata;
            buf_pc_n    = req_addr;
            buf_valid_n = 1'b1;
            req_addr_n  = req_addr + 32'd4;
            state_n     = FULL;
          end
        end else if (branch_taken) begin
          tgt_addr_n = branch_addr;
          state_n    = DROP;
        end
      end
      DROP: begin
        if (branch_taken) tgt_addr_n = branch_addr;
        if (imem_ack) begin
          req_addr_n = branch_taken ? branch_addr : tgt_addr;
          state_n    = FETCH;
        end
      end
      FULL: begin
        if (branch_taken) begin
          buf_valid_n = 1'b0;
          req_addr_n  = branch_addr;
          state_n     = FETCH;
        end else if (!freeze) begin
          buf_valid_n = 1'b0;
          state_n     = FETCH;
        end
      end
      default: begin
        buf_valid_n = 1'b0;
        state_n     = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: random imem latency, freezes, redirects, resets.
// Expected program-order stream is queued by the driver, checked by a monitor.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        if_valid;

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .PC(PC),
    .Instruction(Instruction),
    .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        q[$];
  logic [31:0] next_fill;

  // memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // the fetch stream restarts at a new address: drop everything pending
  task automatic restart(input logic [31:0] a);
    q.delete();
    next_fill = a;
  endtask

  task automatic top_up();
    exp_t e;
    while (q.size() < 4) begin
      e.pc  = next_fill + 32'd4;
      e.ins = mem(next_fill);
      q.push_back(e);
      next_fill = next_fill + 32'd4;
    end
  endtask

  // knobs
  int max_lat = 0;
  int p_fr    = 0;
  int p_br    = 0;
  int p_rst   = 0;
  bit alt_mode = 1'b0;
  bit mon_en   = 1'b0;
  int pops     = 0;

  // imem model state
  bit          busy = 1'b0;
  int          cnt  = 0;
  logic [31:0] lat_addr = 32'b0;
  bit          ack_real = 1'b0;

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0: a = 32'hFFFF_FFF8;
      1: a = $urandom;
      2: a = $urandom & 32'h0000_0FFC;
      default: a = 32'h0000_0100;
    endcase
    return a;
  endfunction

  // one cycle: drive inputs, let the edge pass, account for what was sampled
  task automatic step();
    rst          = (p_rst > 0) && ($urandom_range(0, 999) < p_rst);
    freeze       = ($urandom_range(0, 99) < p_fr);
    branch_taken = ($urandom_range(0, 99) < p_br);
    branch_addr  = branch_taken ? pick_addr() : $urandom;
    imem_ack     = 1'b0;
    imem_rdata   = $urandom;
    ack_real     = 1'b0;
    if (imem_req) begin
      if (!busy) begin
        busy     = 1'b1;
        cnt      = $urandom_range(0, max_lat);
        lat_addr = imem_addr;
      end else begin
        check("addr_stable", imem_addr, lat_addr);
      end
      if (cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(lat_addr);
        ack_real   = 1'b1;
      end else begin
        cnt--;
      end
    end else begin
      if (busy) fail("req_dropped_midflight");
      imem_ack = $urandom_range(0, 1);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      restart(RPC);
      busy = 1'b0;
    end else begin
      if (branch_taken) restart(branch_addr);
      if (ack_real) busy = 1'b0;
    end
    top_up();
  endtask

  // monitor state
  bit          prev_v   = 1'b0;
  bit          prev_fr  = 1'b0;
  bit          prev_br  = 1'b0;
  bit          prev_rst = 1'b0;
  bit          alt_ok   = 1'b0;
  logic [31:0] prev_pc  = 32'b0;
  logic [31:0] prev_ins = 32'b0;
  int          idle     = 0;

  // compare each newly presented instruction with the queue head
  always @(negedge clk) begin
    if (mon_en) begin
      bit   held;
      exp_t e;
      held = prev_v && prev_fr && !prev_br && !prev_rst;
      check("req_vs_valid", {31'b0, imem_req}, {31'b0, ~if_valid});
      if (!if_valid) begin
        check("bubble_pc", PC, 32'b0);
        check("bubble_instr", Instruction, 32'b0);
        idle++;
      end else if (held) begin
        check("held_pc", PC, prev_pc);
        check("held_instr", Instruction, prev_ins);
      end else if (q.size() == 0) begin
        fail("queue_empty");
      end else begin
        e = q.pop_front();
        pops++;
        idle = 0;
        check("pc", PC, e.pc);
        check("instr", Instruction, e.ins);
      end
      if (idle >= 200) begin
        fail("no_progress");
        idle = 0;
      end
      if (alt_mode && alt_ok)
        check("alternate", {31'b0, if_valid}, {31'b0, ~prev_v});
      alt_ok   = alt_mode;
      prev_v   = if_valid;
      prev_fr  = freeze;
      prev_br  = branch_taken;
      prev_rst = rst;
      prev_pc  = PC;
      prev_ins = Instruction;
    end
  end

  initial begin
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'b0;
    repeat (2) @(posedge clk);
    #1;
    restart(RPC);
    top_up();
    rst = 1'b0;
    check("rst_req", {31'b0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_pc", PC, 32'b0);
    check("rst_instr", Instruction, 32'b0);
    mon_en = 1'b1;

    // zero-wait memory, straight line: one instruction per 2 cycles
    max_lat  = 0;
    alt_mode = 1'b1;
    repeat (24) step();
    alt_mode = 1'b0;

    // freezes only
    p_fr = 50;
    repeat (200) step();

    // everything random, including mid-flight resets
    max_lat = 3;
    p_fr    = 30;
    p_br    = 10;
    p_rst   = 12;
    repeat (4000) step();

    // quiet tail so the last fetches drain
    p_br  = 0;
    p_rst = 0;
    p_fr  = 0;
    repeat (20) step();

    checks++;
    if (pops < 300) begin
      errors++;
      $display("FAIL progress got %0d want >=300", pops);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
